st_to_mm_read_fifo: RTL and testbench

- Stream-to-memory-mapped bridge: Avalon-ST sink (data + channel/error sideband) feeding a single-clock circular FIFO, drained by an Avalon-MM read slave.
- Companion to the MM-write-to-ST-source FIFO. Lets the HPS or a DMA pull FPGA-generated samples.
- Same sideband bit layout as the write-side bridge: error in [23:16], channel in [15:8].

---
 rtl/st_to_mm_read_fifo_pkg.sv | 27 ++
 rtl/st_to_mm_read_fifo_mem.sv | 63 ++++++
 rtl/st_to_mm_read_fifo.sv | 112 +++++++++++
 tb/tb_st_to_mm_read_fifo.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/st_to_mm_read_fifo_pkg.sv
// Shared constants and types for the stream-to-MM read FIFO bridge.
// The sideband layout matches the write-side bridge: error in [23:16], channel in [15:8].
package st_to_mm_read_fifo_pkg;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_INFO   = 2'd1;
  localparam logic [1:0] ADDR_STATUS = 2'd2;

  localparam int STATUS_EMPTY_BIT = 31;
  localparam int STATUS_FULL_BIT  = 30;
  localparam int INFO_ERR_LSB     = 16;
  localparam int INFO_CH_LSB      = 8;

  localparam int ENTRY_DATA_W = 32;

  typedef struct packed {
    logic [7:0] error;
    logic [7:0] channel;
  } info_t;

  typedef struct packed {
    logic [7:0]              error;
    logic [7:0]              channel;
    logic [ENTRY_DATA_W-1:0] data;
  } entry_t;

endpackage

// File: rtl/st_to_mm_read_fifo_mem.sv
// Single-clock circular FIFO storage with pointers, fill count and flags.
// The head entry is read combinationally; a push is visible at the head from the next cycle.
module st_to_mm_read_fifo_mem
  import st_to_mm_read_fifo_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              i_push,
  input  info_t             i_push_info,
  input  logic [DATA_W-1:0] i_push_data,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_head_data,
  output info_t             o_head_info,
  output logic              o_empty,
  output logic              o_full,
  output logic [ADDR_W:0]   o_count
);

  info_t             r_info_ram [DEPTH];
  logic [DATA_W-1:0] r_data_ram [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;

  // Storage is deliberately left uncleared by reset.
  always_ff @(posedge clock) begin
    if (i_push) begin
      r_info_ram[r_wr_ptr] <= i_push_info;
      r_data_ram[r_wr_ptr] <= i_push_data;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= ADDR_W'(0);
      r_rd_ptr <= ADDR_W'(0);
      r_count  <= (ADDR_W+1)'(0);
    end else begin
      if (i_push) begin
        r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
      end
      if (i_pop) begin
        r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
      end
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + (ADDR_W+1)'(1);
        2'b01:   r_count <= r_count - (ADDR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head_data = r_data_ram[r_rd_ptr];
  assign o_head_info = r_info_ram[r_rd_ptr];
  assign o_empty     = (r_count == (ADDR_W+1)'(0));
  assign o_full      = (r_count == (ADDR_W+1)'(DEPTH));
  assign o_count     = r_count;

endmodule

// File: rtl/st_to_mm_read_fifo.sv
// Avalon-ST sink to Avalon-MM read slave bridge: MM decode, info latch, readdata and irq.
// Optional fill-level interrupt enabled by defining ST_TO_MM_READ_FIFO_IRQ_EN.
module st_to_mm_read_fifo
  import st_to_mm_read_fifo_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int DEPTH      = 32,
  parameter int ADDR_W     = 5,
  parameter int IRQ_THRESH = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] st_sink_data,
  input  logic [7:0]        st_sink_channel,
  input  logic [7:0]        st_sink_error,
  input  logic              st_sink_valid,
  output logic              st_sink_ready,
  input  logic [1:0]        mm_read_slave_address,
  input  logic              mm_read_slave_read,
  output logic [31:0]       mm_read_slave_readdata,
  output logic              mm_read_slave_waitrequest,
  output logic              irq
);

  if ((DEPTH != (1 << ADDR_W)) || (IRQ_THRESH > DEPTH)) begin : g_bad_cfg
    $error("st_to_mm_read_fifo: DEPTH must equal 2**ADDR_W and IRQ_THRESH must not exceed DEPTH");
  end

  logic [DATA_W-1:0] w_head_data;
  info_t             w_head_info;
  logic              w_empty;
  logic              w_full;
  logic [ADDR_W:0]   w_count;
  logic              w_push;
  logic              w_pop;
  logic              w_accept;
  logic [31:0]       w_status;
  logic [31:0]       w_info_word;
  info_t             r_info_q;
  logic [31:0]       r_readdata;

  assign st_sink_ready             = reset_n & ~w_full;
  assign w_push                    = st_sink_valid & st_sink_ready;
  assign mm_read_slave_waitrequest = ~reset_n | ((mm_read_slave_address == ADDR_DATA) & w_empty);
  assign w_accept                  = mm_read_slave_read & ~mm_read_slave_waitrequest;
  assign w_pop                     = w_accept & (mm_read_slave_address == ADDR_DATA);

  st_to_mm_read_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clock       (clock),
    .reset_n     (reset_n),
    .i_push      (w_push),
    .i_push_info ('{error: st_sink_error, channel: st_sink_channel}),
    .i_push_data (st_sink_data),
    .i_pop       (w_pop),
    .o_head_data (w_head_data),
    .o_head_info (w_head_info),
    .o_empty     (w_empty),
    .o_full      (w_full),
    .o_count     (w_count)
  );

  always_comb begin
    w_status                   = 32'd0;
    w_status[STATUS_EMPTY_BIT] = w_empty;
    w_status[STATUS_FULL_BIT]  = w_full;
    w_status[ADDR_W:0]         = w_count;
    w_info_word                                 = 32'd0;
    w_info_word[INFO_ERR_LSB +: 8]              = r_info_q.error;
    w_info_word[INFO_CH_LSB +: 8]               = r_info_q.channel;
  end

  // readdata holds its value until the next accepted read.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_readdata <= 32'd0;
      r_info_q   <= '{error: 8'd0, channel: 8'd0};
    end else if (w_accept) begin
      case (mm_read_slave_address)
        ADDR_DATA: begin
          r_readdata <= 32'(w_head_data);
          r_info_q   <= w_head_info;
        end
        ADDR_INFO:   r_readdata <= w_info_word;
        ADDR_STATUS: r_readdata <= w_status;
        default:     r_readdata <= 32'd0;
      endcase
    end
  end

  assign mm_read_slave_readdata = r_readdata;

`ifdef ST_TO_MM_READ_FIFO_IRQ_EN
  logic r_irq;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= (w_count >= (ADDR_W+1)'(IRQ_THRESH));
    end
  end

  assign irq = r_irq;
`else
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_st_to_mm_read_fifo.sv
// Directed bench for st_to_mm_read_fifo; irq expectations follow ST_TO_MM_READ_FIFO_IRQ_EN.
module tb_st_to_mm_read_fifo;

`ifdef ST_TO_MM_READ_FIFO_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] st_sink_data = 32'd0;
  logic [7:0]  st_sink_channel = 8'd0;
  logic [7:0]  st_sink_error = 8'd0;
  logic        st_sink_valid = 1'b0;
  logic        st_sink_ready;
  logic [1:0]  mm_read_slave_address = 2'd0;
  logic        mm_read_slave_read = 1'b0;
  logic [31:0] mm_read_slave_readdata;
  logic        mm_read_slave_waitrequest;
  logic        irq;

  int total = 0;
  int bad = 0;

  st_to_mm_read_fifo dut (
    .clock                     (clock),
    .reset_n                   (reset_n),
    .st_sink_data              (st_sink_data),
    .st_sink_channel           (st_sink_channel),
    .st_sink_error             (st_sink_error),
    .st_sink_valid             (st_sink_valid),
    .st_sink_ready             (st_sink_ready),
    .mm_read_slave_address     (mm_read_slave_address),
    .mm_read_slave_read        (mm_read_slave_read),
    .mm_read_slave_readdata    (mm_read_slave_readdata),
    .mm_read_slave_waitrequest (mm_read_slave_waitrequest),
    .irq                       (irq)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic push_beat(input logic [31:0] d, input logic [7:0] ch, input logic [7:0] er);
    int n = 0;
    st_sink_data = d; st_sink_channel = ch; st_sink_error = er; st_sink_valid = 1'b1;
    while (!st_sink_ready && n < 200) begin
      @(negedge clock); n++;
    end
    if (n >= 200) chk("push_timeout", 32'(n), 32'd0);
    @(negedge clock);
    st_sink_valid = 1'b0;
  endtask

  task automatic mm_rd(input logic [1:0] a, output logic [31:0] d);
    int n = 0;
    mm_read_slave_address = a; mm_read_slave_read = 1'b1;
    while (mm_read_slave_waitrequest && n < 200) begin
      @(negedge clock); n++;
    end
    if (n >= 200) chk("read_timeout", 32'(n), 32'd0);
    @(negedge clock);
    mm_read_slave_read = 1'b0;
    d = mm_read_slave_readdata;
  endtask

  initial begin
    logic [31:0] rd;

    // Reset, then a little traffic so a later reset lands mid-operation.
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    push_beat(32'hAAAA0001, 8'h12, 8'h34);
    push_beat(32'hAAAA0002, 8'h12, 8'h34);
    mm_rd(2'd0, rd);
    chk("pre_reset_data", rd, 32'hAAAA0001);
    st_sink_valid = 1'b1; st_sink_data = 32'hAAAA0003;
    #1 reset_n = 1'b0;
    #1;
    chk("rst_ready", 32'(st_sink_ready), 32'd0);
    chk("rst_wait", 32'(mm_read_slave_waitrequest), 32'd1);
    chk("rst_readdata", mm_read_slave_readdata, 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    st_sink_valid = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    #1;
    chk("post_rst_ready", 32'(st_sink_ready), 32'd1);
    chk("post_rst_wait_empty", 32'(mm_read_slave_waitrequest), 32'd1);
    @(negedge clock);
    mm_rd(2'd2, rd);
    chk("post_rst_status", rd, 32'h80000000);
    mm_rd(2'd1, rd);
    chk("post_rst_info", rd, 32'h00000000);
    mm_read_slave_address = 2'd0; mm_read_slave_read = 1'b1;
    repeat (3) @(negedge clock);
    chk("stall_wait", 32'(mm_read_slave_waitrequest), 32'd1);
    chk("stall_hold", mm_read_slave_readdata, 32'h00000000);
    mm_read_slave_read = 1'b0;
    mm_rd(2'd3, rd);
    chk("addr3", rd, 32'd0);

    // Three words in order.
    push_beat(32'h11111111, 8'h05, 8'h00);
    push_beat(32'h22222222, 8'h05, 8'h00);
    push_beat(32'h33333333, 8'h05, 8'h00);
    mm_rd(2'd2, rd);
    chk("status3", rd, 32'h00000003);
    mm_rd(2'd0, rd); chk("data1", rd, 32'h11111111);
    mm_rd(2'd0, rd); chk("data2", rd, 32'h22222222);
    mm_rd(2'd0, rd); chk("data3", rd, 32'h33333333);
    mm_rd(2'd2, rd);
    chk("status_empty", rd, 32'h80000000);
    mm_rd(2'd1, rd);
    chk("info_ch5", rd, 32'h00000500);

    // Fill to full; irq lags the count by one cycle.
    for (int i = 0; i < 32; i++) begin
      push_beat(32'h10000000 + 32'(i), 8'h00, 8'h00);
      chk("fill_irq", 32'(irq), 32'(IRQ_ON && (i >= 16)));
    end
    chk("full_ready", 32'(st_sink_ready), 32'd0);
    mm_rd(2'd2, rd);
    chk("status_full", rd, 32'h40000020);
    st_sink_data = 32'hCAFE0033; st_sink_channel = 8'h00; st_sink_error = 8'h00;
    st_sink_valid = 1'b1;
    repeat (3) @(negedge clock);
    chk("held_ready", 32'(st_sink_ready), 32'd0);
    mm_rd(2'd0, rd);
    chk("full_pop", rd, 32'h10000000);
    chk("reopen_ready", 32'(st_sink_ready), 32'd1);
    @(negedge clock);
    st_sink_valid = 1'b0;
    mm_rd(2'd2, rd);
    chk("status_refull", rd, 32'h40000020);
    for (int k = 1; k <= 32; k++) begin
      mm_rd(2'd0, rd);
      chk("drain", rd, (k == 32) ? 32'hCAFE0033 : 32'h10000000 + 32'(k));
      chk("drain_irq", 32'(irq), 32'(IRQ_ON && ((33 - k) >= 16)));
    end
    mm_rd(2'd2, rd);
    chk("status_drained", rd, 32'h80000000);

    // Sideband capture.
    push_beat(32'hDEADBEEF, 8'h3C, 8'h81);
    mm_rd(2'd0, rd);
    chk("beef_data", rd, 32'hDEADBEEF);
    mm_rd(2'd1, rd);
    chk("beef_info", rd, 32'h00813C00);

    // Steady push+pop at count 4 across many pointer wraps.
    for (int i = 0; i < 4; i++) push_beat(32'h50000000 + 32'(i), 8'h00, 8'h00);
    for (int i = 0; i < 100; i++) begin
      st_sink_data = 32'h50000004 + 32'(i); st_sink_valid = 1'b1;
      mm_read_slave_address = 2'd0; mm_read_slave_read = 1'b1;
      @(negedge clock);
      chk("stream", mm_read_slave_readdata, 32'h50000000 + 32'(i));
    end
    st_sink_valid = 1'b0; mm_read_slave_read = 1'b0;
    mm_rd(2'd2, rd);
    chk("stream_count", rd, 32'h00000004);
    for (int i = 0; i < 4; i++) begin
      mm_rd(2'd0, rd);
      chk("stream_tail", rd, 32'h50000064 + 32'(i));
    end

    // Read on empty stalls, then completes once a word lands.
    mm_read_slave_address = 2'd0; mm_read_slave_read = 1'b1;
    repeat (3) @(negedge clock);
    chk("empty_stall", 32'(mm_read_slave_waitrequest), 32'd1);
    st_sink_data = 32'h00000077; st_sink_valid = 1'b1;
    @(negedge clock);
    st_sink_valid = 1'b0;
    chk("stall_release", 32'(mm_read_slave_waitrequest), 32'd0);
    @(negedge clock);
    mm_read_slave_read = 1'b0;
    chk("stall_data", mm_read_slave_readdata, 32'h00000077);
    mm_rd(2'd2, rd);
    chk("final_status", rd, 32'h80000000);
    chk("final_irq", 32'(irq), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
